// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-frame peak bin/magnitude search over an FFT output stream.
// Optional FFT_PEAK_AMBM_EN selects alpha-max-beta-min magnitude instead of |re|+|im|.
// busy also covers the cycle that presents a frame's first sample, so back-to-back frames keep it high.
module fft_peak_detect #(
    parameter int N_PT = 1024,
    parameter int AW   = 10,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            di_en,
    input  logic            di_last,
    input  logic [2*DW-1:0] din,
    input  logic [AW-1:0]   search_lo,
    input  logic [AW-1:0]   search_hi,
    output logic            pk_valid,
    output logic [AW-1:0]   pk_bin,
    output logic [DW:0]     pk_mag,
    output logic            pk_err,
    output logic            busy
);
    typedef enum logic {IDLE, ACC} state_t;
    state_t state;
    logic [AW-1:0] cnt, lo_q, hi_q, cur_bin, lo_c, hi_c;
    logic at_end_bin, frame_end, cur_win;
    logic v0, v1, v2;
    logic [2*DW-1:0] d0;
    logic [AW+3:0] m0, m1, m2;
    logic [DW-1:0] a_re, a_im;
    logic [DW:0] mag_c, mag2, best_mag, base_mag, nxt_mag;
    logic [AW-1:0] best_bin, base_bin, nxt_bin, b2;
    logic w2, f2, l2, e2, take;
`ifdef FFT_PEAK_AMBM_EN
    logic [DW-1:0] mx, mn;
`endif

    function automatic logic [DW-1:0] abs_v(input logic [DW-1:0] x);
        return x[DW-1] ? -x : x;
    endfunction

    // Bin position of the current sample, window test against latched (or first-sample) bounds
    always_comb begin
        cur_bin    = (state == IDLE) ? '0 : cnt;
        lo_c       = (state == IDLE) ? search_lo : lo_q;
        hi_c       = (state == IDLE) ? search_hi : hi_q;
        at_end_bin = cur_bin == AW'(N_PT - 1);
        frame_end  = di_last | at_end_bin;
        cur_win    = (cur_bin >= lo_c) && (cur_bin <= hi_c);
    end

    // Frame FSM: latch the window at frame start, count bins, return to IDLE at frame end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            lo_q  <= '0;
            hi_q  <= '0;
        end else if (di_en) begin
            if (state == IDLE) begin
                lo_q <= search_lo;
                hi_q <= search_hi;
            end
            state <= frame_end ? IDLE : ACC;
            cnt   <= cur_bin + 1'b1;
        end
    end

    // Magnitude from the registered absolute values
    always_comb begin
`ifdef FFT_PEAK_AMBM_EN
        mx    = (a_re > a_im) ? a_re : a_im;
        mn    = (a_re > a_im) ? a_im : a_re;
        mag_c = {1'b0, mx} + (DW+1)'(mn >> 1);
`else
        mag_c = {1'b0, a_re} + {1'b0, a_im};
`endif
    end

    // Free-running pipeline carrying {bin, in-window, first, last, err} alongside the data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0   <= 1'b0;
            v1   <= 1'b0;
            v2   <= 1'b0;
            d0   <= '0;
            m0   <= '0;
            m1   <= '0;
            m2   <= '0;
            a_re <= '0;
            a_im <= '0;
            mag2 <= '0;
        end else begin
            v0 <= di_en;
            v1 <= v0;
            v2 <= v1;
            if (di_en) begin
                d0 <= din;
                m0 <= {cur_bin, cur_win, state == IDLE, frame_end, di_last != at_end_bin};
            end
            if (v0) begin
                a_re <= abs_v(d0[DW-1:0]);
                a_im <= abs_v(d0[2*DW-1:DW]);
                m1   <= m0;
            end
            if (v1) begin
                mag2 <= mag_c;
                m2   <= m1;
            end
        end
    end

    // Candidate selection: strict greater-than keeps the lowest index on ties
    always_comb begin
        {b2, w2, f2, l2, e2} = m2;
        base_mag = f2 ? '0 : best_mag;
        base_bin = f2 ? '0 : best_bin;
        take     = w2 && (mag2 > base_mag);
        nxt_mag  = take ? mag2 : base_mag;
        nxt_bin  = take ? b2 : base_bin;
    end

    // Running peak update and end-of-frame result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_mag <= '0;
            best_bin <= '0;
            pk_valid <= 1'b0;
            pk_bin   <= '0;
            pk_mag   <= '0;
            pk_err   <= 1'b0;
        end else begin
            pk_valid <= v2 && l2;
            if (v2) begin
                best_mag <= nxt_mag;
                best_bin <= nxt_bin;
                if (l2) begin
                    pk_bin <= nxt_bin;
                    pk_mag <= nxt_mag;
                    pk_err <= e2;
                end
            end
        end
    end

    assign busy = (state == ACC) | di_en;
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: table-driven and randomized checks of fft_peak_detect against a frame-level model.
module tb_fft_peak_detect;
    localparam int N = 1024;
`ifdef FFT_PEAK_AMBM_EN
    localparam bit AMBM = 1'b1;
`else
    localparam bit AMBM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, di_en, di_last;
    logic [31:0] din;
    logic [9:0] search_lo, search_hi, pk_bin;
    logic [16:0] pk_mag;
    logic pk_valid, pk_err, busy;

    fft_peak_detect dut (
        .clk(clk), .rst(rst), .di_en(di_en), .di_last(di_last), .din(din),
        .search_lo(search_lo), .search_hi(search_hi),
        .pk_valid(pk_valid), .pk_bin(pk_bin), .pk_mag(pk_mag), .pk_err(pk_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0, bad = 0;

    typedef struct {int bin; int mag; bit err; int at;} res_t;
    res_t expq[$];
    res_t mon_r;
    logic [31:0] fd [N];

    typedef struct {
        int lo, hi, len; bit last;
        int b0; logic [31:0] d0;
        int b1; logic [31:0] d1;
        int b2; logic [31:0] d2;
        int ebin, emag; bit eerr;
    } vec_t;
    vec_t tbl[9];

    // Every result strobe is matched against the oldest expected frame result, including its cycle
    always @(negedge clk) begin
        if (pk_valid) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pk_valid cyc=%0d bin=%0d mag=%0d", cyc, pk_bin, pk_mag);
            end else begin
                mon_r = expq.pop_front();
                if (cyc != mon_r.at || pk_bin != 10'(mon_r.bin) || pk_mag != 17'(mon_r.mag) || pk_err != mon_r.err) begin
                    bad++;
                    $display("FAIL result got cyc=%0d bin=%0d mag=%0d err=%0d want cyc=%0d bin=%0d mag=%0d err=%0d",
                             cyc, pk_bin, pk_mag, pk_err, mon_r.at, mon_r.bin, mon_r.mag, mon_r.err);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int magf(input logic [31:0] d);
        int re, im, ar, ai;
        re = $signed(d[15:0]);
        im = $signed(d[31:16]);
        ar = re < 0 ? -re : re;
        ai = im < 0 ? -im : im;
        if (AMBM) return (ar > ai ? ar : ai) + (ar > ai ? ai : ar) / 2;
        return ar + ai;
    endfunction

    function automatic res_t model(input int lo, input int hi, input int len, input bit last, input int at);
        res_t r;
        r.bin = 0;
        r.mag = 0;
        for (int i = 0; i < len; i++)
            if (i >= lo && i <= hi && magf(fd[i]) > r.mag) begin
                r.mag = magf(fd[i]);
                r.bin = i;
            end
        r.err = last ? (len != N) : 1'b1;
        r.at  = at;
        return r;
    endfunction

    task automatic send_frame(input int lo, input int hi, input int len, input bit last,
                              input bit gaps, input bit b2b, output int end_cyc);
        search_lo = 10'(lo);
        search_hi = 10'(hi);
        for (int i = 0; i < len; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
                di_en = 1'b0;
                di_last = 1'b0;
                din = $urandom;
                repeat ($urandom_range(1, 3)) begin
                    tick;
                    chk("busy_gap", int'(busy), 1);
                end
            end
            di_en = 1'b1;
            din = fd[i];
            di_last = last && (i == len - 1);
            if (b2b && i == 0) begin
                #1;
                chk("busy_boundary", int'(busy), 1);
            end
            tick;
            if (i == 0) begin
                search_lo = 10'($urandom);
                search_hi = 10'($urandom);
            end
        end
        end_cyc = cyc;
        di_en = 1'b0;
        di_last = 1'b0;
    endtask

    task automatic clear_fd;
        for (int i = 0; i < N; i++) fd[i] = '0;
    endtask

    initial begin
        int e;
        res_t r;
        tbl[0] = '{0, 1023, 1024, 1, 100, 32'h0000_03E8, 100, 32'h0000_03E8, 100, 32'h0000_03E8, 100, 1000, 0};
        tbl[1] = '{20, 900, 1024, 1, 50, 32'h012C_FE70, 60, 32'h012C_FE70, 10, 32'h0000_1388, 50, AMBM ? 550 : 700, 0};
        tbl[2] = '{0, 1023, 1024, 1, 5, 32'h8000_8000, 5, 32'h8000_8000, 5, 32'h8000_8000, 5, AMBM ? 49152 : 65536, 0};
        tbl[3] = '{0, 1023, 512, 1, 200, 32'h0000_FFF9, 200, 32'h0000_FFF9, 200, 32'h0000_FFF9, 200, 7, 1};
        tbl[4] = '{0, 1023, 1024, 0, 1023, 32'h0003_0004, 1023, 32'h0003_0004, 1023, 32'h0003_0004, 1023, AMBM ? 5 : 7, 1};
        tbl[5] = '{600, 100, 1024, 1, 300, 32'h0000_03E8, 300, 32'h0000_03E8, 300, 32'h0000_03E8, 0, 0, 0};
        tbl[6] = '{800, 900, 100, 1, 50, 32'h0000_03E8, 50, 32'h0000_03E8, 50, 32'h0000_03E8, 0, 0, 1};
        tbl[7] = '{60, 60, 1024, 1, 59, 32'h0000_0100, 60, 32'h0000_0100, 61, 32'h0000_0100, 60, 256, 0};
        tbl[8] = '{10, 500, 1024, 1, 501, 32'h0000_7FFF, 500, 32'h0000_0010, 9, 32'h0000_7FFF, 500, 16, 0};

        rst = 1'b0; di_en = 1'b0; di_last = 1'b0; din = '0; search_lo = '0; search_hi = '0;
        repeat (3) tick;
        chk("rst_pk_valid", int'(pk_valid), 0);
        chk("rst_pk_bin", int'(pk_bin), 0);
        chk("rst_pk_mag", int'(pk_mag), 0);
        chk("rst_pk_err", int'(pk_err), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b1;
        tick;

        for (int k = 0; k < 9; k++) begin
            clear_fd();
            fd[tbl[k].b0] = tbl[k].d0;
            fd[tbl[k].b1] = tbl[k].d1;
            fd[tbl[k].b2] = tbl[k].d2;
            send_frame(tbl[k].lo, tbl[k].hi, tbl[k].len, tbl[k].last, 1'b0, 1'b0, e);
            expq.push_back('{tbl[k].ebin, tbl[k].emag, tbl[k].eerr, e + 3});
            tick;
            chk("busy_idle", int'(busy), 0);
            tick;
        end

        // back-to-back frames with gaps, peaks at 7 then 900
        for (int i = 0; i < N; i++) fd[i] = {16'($urandom_range(0, 50)), 16'($urandom_range(0, 50))};
        fd[7] = 32'h0000_4000;
        send_frame(0, 1023, 1024, 1, 1'b1, 1'b0, e);
        r = model(0, 1023, 1024, 1, e + 3);
        chk("b2b_model_bin1", r.bin, 7);
        expq.push_back(r);
        for (int i = 0; i < N; i++) fd[i] = {16'($urandom_range(0, 50)), 16'($urandom_range(0, 50))};
        fd[900] = 32'h0000_4000;
        send_frame(500, 1000, 1024, 1, 1'b1, 1'b1, e);
        r = model(500, 1000, 1024, 1, e + 3);
        chk("b2b_model_bin2", r.bin, 900);
        expq.push_back(r);
        repeat (2) tick;

        // randomized frames: random window, length, gaps; half with small values to provoke ties
        for (int k = 0; k < 4; k++) begin
            int lo, hi, len;
            bit last;
            logic [31:0] v;
            lo = $urandom_range(0, 1023);
            hi = $urandom_range(0, 1023);
            len = $urandom_range(1, 1024);
            last = (len < N) || ($urandom_range(0, 1) == 1);
            for (int i = 0; i < N; i++) begin
                v = $urandom;
                fd[i] = k[0] ? {{13{v[18]}}, v[18:16], {13{v[2]}}, v[2:0]} : v;
            end
            send_frame(lo, hi, len, last, 1'b1, 1'b0, e);
            expq.push_back(model(lo, hi, len, last, e + 3));
            repeat ($urandom_range(0, 2)) tick;
        end
        repeat (5) tick;

        // reset in the middle of a frame discards it
        for (int i = 0; i < N; i++) fd[i] = $urandom;
        send_frame(0, 1023, 300, 1'b0, 1'b0, 1'b0, e);
        di_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_pk_valid", int'(pk_valid), 0);
        chk("midrst_pk_bin", int'(pk_bin), 0);
        chk("midrst_pk_mag", int'(pk_mag), 0);
        chk("midrst_pk_err", int'(pk_err), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (4) tick;
        rst = 1'b1;
        repeat (2) tick;
        clear_fd();
        fd[333] = 32'h0000_0123;
        send_frame(0, 1023, 1024, 1, 1'b0, 1'b0, e);
        expq.push_back('{333, 291, 1'b0, e + 3});

        repeat (10) tick;
        chk("pending_results", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
